// File: rtl/intrapred_pkg.sv
// rtl/intrapred_pkg.sv - shared types, widths and pixel clip for luma 4x4 intra prediction/reconstruction
package intrapred_pkg;

    localparam int PIX_W = 8;
    localparam int RES_W = 9;

    typedef enum logic [2:0] {
        MODE_V   = 3'd0,
        MODE_H   = 3'd1,
        MODE_DDL = 3'd2,
        MODE_DDR = 3'd3,
        MODE_VR  = 3'd4,
        MODE_HD  = 3'd5,
        MODE_VL  = 3'd6,
        MODE_HU  = 3'd7
    } luma4x4_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRED   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } recon_state_t;

    localparam logic signed [RES_W:0] PIX_MAX = (RES_W+1)'(255);

    function automatic logic [PIX_W-1:0] clip_pix(input logic signed [RES_W:0] s);
        logic [PIX_W-1:0] v;
        if (s[RES_W]) begin
            v = '0;
        end else if (s > PIX_MAX) begin
            v = '1;
        end else begin
            v = PIX_W'(s);
        end
        return v;
    endfunction

endpackage

// File: rtl/predgen_luma4x4.sv
// rtl/predgen_luma4x4.sv - combinational 4x4 luma intra predictor (all directional modes, no DC)
module predgen_luma4x4
    import intrapred_pkg::*;
(
    input  logic [2:0]          mode,
    input  logic [8*PIX_W-1:0]  top,
    input  logic [5*PIX_W-1:0]  left,
    output logic [16*PIX_W-1:0] pred
);

    localparam int SUM_W = PIX_W + 2;

    // (x,-1) addresses A..H, (-1,y) addresses I..L, (-1,-1) is the corner M
    function automatic logic [PIX_W-1:0] nb(input logic [8*PIX_W-1:0] t, input logic [5*PIX_W-1:0] l,
                                            input int x, input int y);
        logic [PIX_W-1:0] v;
        if (y < 0) begin
            v = (x < 0) ? l[PIX_W-1:0] : t[x*PIX_W +: PIX_W];
        end else begin
            v = l[(y+1)*PIX_W +: PIX_W];
        end
        return v;
    endfunction

    function automatic logic [PIX_W-1:0] avg2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b) + SUM_W'(1);
        return PIX_W'(s >> 1);
    endfunction

    function automatic logic [PIX_W-1:0] avg3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c) + SUM_W'(2);
        return PIX_W'(s >> 2);
    endfunction

    function automatic logic [PIX_W-1:0] pred_px(input luma4x4_mode_t m, input logic [8*PIX_W-1:0] t,
                                                 input logic [5*PIX_W-1:0] l, input int x, input int y);
        logic [PIX_W-1:0] v;
        int zv, zh, zu, hy, hx;
        zv = 2*x - y;
        zh = 2*y - x;
        zu = x + 2*y;
        hy = y >> 1;
        hx = x >> 1;
        v  = '0;
        case (m)
            MODE_V:   v = nb(t, l, x, -1);
            MODE_H:   v = nb(t, l, -1, y);
            MODE_DDL: begin
                if (x == 3 && y == 3) v = avg3(nb(t, l, 6, -1), nb(t, l, 7, -1), nb(t, l, 7, -1));
                else v = avg3(nb(t, l, x+y, -1), nb(t, l, x+y+1, -1), nb(t, l, x+y+2, -1));
            end
            MODE_DDR: begin
                if (x > y)      v = avg3(nb(t, l, x-y-2, -1), nb(t, l, x-y-1, -1), nb(t, l, x-y, -1));
                else if (x < y) v = avg3(nb(t, l, -1, y-x-2), nb(t, l, -1, y-x-1), nb(t, l, -1, y-x));
                else            v = avg3(nb(t, l, 0, -1), nb(t, l, -1, -1), nb(t, l, -1, 0));
            end
            MODE_VR: begin
                if (zv >= 0 && !zv[0]) v = avg2(nb(t, l, x-hy-1, -1), nb(t, l, x-hy, -1));
                else if (zv > 0)       v = avg3(nb(t, l, x-hy-2, -1), nb(t, l, x-hy-1, -1), nb(t, l, x-hy, -1));
                else if (zv == -1)     v = avg3(nb(t, l, -1, 0), nb(t, l, -1, -1), nb(t, l, 0, -1));
                else                   v = avg3(nb(t, l, -1, y-1), nb(t, l, -1, y-2), nb(t, l, -1, y-3));
            end
            MODE_HD: begin
                if (zh >= 0 && !zh[0]) v = avg2(nb(t, l, -1, y-hx-1), nb(t, l, -1, y-hx));
                else if (zh > 0)       v = avg3(nb(t, l, -1, y-hx-2), nb(t, l, -1, y-hx-1), nb(t, l, -1, y-hx));
                else if (zh == -1)     v = avg3(nb(t, l, -1, 0), nb(t, l, -1, -1), nb(t, l, 0, -1));
                else                   v = avg3(nb(t, l, x-1, -1), nb(t, l, x-2, -1), nb(t, l, x-3, -1));
            end
            MODE_VL: begin
                if (!y[0]) v = avg2(nb(t, l, x+hy, -1), nb(t, l, x+hy+1, -1));
                else       v = avg3(nb(t, l, x+hy, -1), nb(t, l, x+hy+1, -1), nb(t, l, x+hy+2, -1));
            end
            MODE_HU: begin
                if (zu > 5)       v = nb(t, l, -1, 3);
                else if (zu == 5) v = avg3(nb(t, l, -1, 2), nb(t, l, -1, 3), nb(t, l, -1, 3));
                else if (!zu[0])  v = avg2(nb(t, l, -1, y+hx), nb(t, l, -1, y+hx+1));
                else              v = avg3(nb(t, l, -1, y+hx), nb(t, l, -1, y+hx+1), nb(t, l, -1, y+hx+2));
            end
            default:  v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        pred = '0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                pred[(y*4 + x)*PIX_W +: PIX_W] = pred_px(luma4x4_mode_t'(mode), top, left, x, y);
            end
        end
    end

endmodule

// File: rtl/intrarecon_luma4x4.sv
// rtl/intrarecon_luma4x4.sv - luma 4x4 intra reconstruction: latch prediction, add streamed residual rows, clip
module intrarecon_luma4x4 #(
    parameter int RES_W = 9,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           mode,
    input  logic [8*PIX_W-1:0]   top,
    input  logic [5*PIX_W-1:0]   left,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [4*RES_W-1:0]   res_row,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [4*PIX_W-1:0]   rec_row,
    output logic [1:0]           rec_idx,
    output logic                 rec_last,
    output logic                 busy
);
    import intrapred_pkg::*;

    recon_state_t          state_q, state_d;
    luma4x4_mode_t         mode_q, mode_d;
    logic [8*PIX_W-1:0]    top_q, top_d;
    logic [5*PIX_W-1:0]    left_q, left_d;
    logic [16*PIX_W-1:0]   pred_q, pred_d;
    logic [1:0]            row_q, row_d;
    logic                  rec_valid_q, rec_valid_d;
    logic [4*PIX_W-1:0]    rec_row_q, rec_row_d;
    logic [1:0]            rec_idx_q, rec_idx_d;
    logic                  rec_last_q, rec_last_d;

    logic [16*PIX_W-1:0]   pred_w;
    logic [4*PIX_W-1:0]    recon_w;
    logic                  rec_hs;
    logic                  res_hs;

    predgen_luma4x4 u_predgen (
        .mode (mode_q),
        .top  (top_q),
        .left (left_q),
        .pred (pred_w)
    );

    // Sum in RES_W+1 signed bits: pixel zero-extended, residual sign-extended
    always_comb begin
        logic signed [RES_W:0] pix_s;
        logic signed [RES_W:0] res_s;
        pix_s   = '0;
        res_s   = '0;
        recon_w = '0;
        for (int c = 0; c < 4; c++) begin
            pix_s = $signed({{(RES_W+1-PIX_W){1'b0}}, pred_q[(int'(row_q)*4 + c)*PIX_W +: PIX_W]});
            res_s = $signed({res_row[c*RES_W + RES_W-1], res_row[c*RES_W +: RES_W]});
            recon_w[c*PIX_W +: PIX_W] = clip_pix(pix_s + res_s);
        end
    end

    assign cmd_ready = reset && (state_q == ST_IDLE);
    assign res_ready = reset && (state_q == ST_STREAM) && (!rec_valid_q || rec_ready);
    assign rec_hs    = rec_valid_q && rec_ready;
    assign res_hs    = res_valid && res_ready;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        top_d       = top_q;
        left_d      = left_q;
        pred_d      = pred_q;
        row_d       = row_q;
        rec_valid_d = rec_valid_q;
        rec_row_d   = rec_row_q;
        rec_idx_d   = rec_idx_q;
        rec_last_d  = rec_last_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    mode_d  = luma4x4_mode_t'(mode);
                    top_d   = top;
                    left_d  = left;
                    state_d = ST_PRED;
                end
            end
            ST_PRED: begin
                pred_d  = pred_w;
                row_d   = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (rec_hs) begin
                    rec_valid_d = 1'b0;
                    rec_last_d  = 1'b0;
                end
                if (res_hs) begin
                    rec_valid_d = 1'b1;
                    rec_row_d   = recon_w;
                    rec_idx_d   = row_q;
                    rec_last_d  = (row_q == 2'd3);
                    row_d       = row_q + 2'd1;
                    if (row_q == 2'd3) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rec_hs) begin
                    rec_valid_d = 1'b0;
                    rec_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_V;
            top_q       <= '0;
            left_q      <= '0;
            pred_q      <= '0;
            row_q       <= '0;
            rec_valid_q <= 1'b0;
            rec_row_q   <= '0;
            rec_idx_q   <= '0;
            rec_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            top_q       <= top_d;
            left_q      <= left_d;
            pred_q      <= pred_d;
            row_q       <= row_d;
            rec_valid_q <= rec_valid_d;
            rec_row_q   <= rec_row_d;
            rec_idx_q   <= rec_idx_d;
            rec_last_q  <= rec_last_d;
        end
    end

    assign rec_valid = rec_valid_q;
    assign rec_row   = rec_row_q;
    assign rec_idx   = rec_idx_q;
    assign rec_last  = rec_last_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_intrarecon_luma4x4.sv
// tb/tb_intrarecon_luma4x4.sv - self-checking bench for intrarecon_luma4x4 against an edge-array reference model
module tb_intrarecon_luma4x4;

    localparam int PIX_W = 8;
    localparam int RES_W = 9;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           mode;
    logic [8*PIX_W-1:0]   top;
    logic [5*PIX_W-1:0]   left;
    logic                 res_valid;
    logic                 res_ready;
    logic [4*RES_W-1:0]   res_row;
    logic                 rec_valid;
    logic                 rec_ready;
    logic [4*PIX_W-1:0]   rec_row;
    logic [1:0]           rec_idx;
    logic                 rec_last;
    logic                 busy;

    intrarecon_luma4x4 #(.RES_W(RES_W), .PIX_W(PIX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .mode      (mode),
        .top       (top),
        .left      (left),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_row   (res_row),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_row   (rec_row),
        .rec_idx   (rec_idx),
        .rec_last  (rec_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Neighbour line L,K,J,I,M,A..H at indices 0..12
    int e [13];
    int res_v [4][4];
    int exp_pix [4][4];

    function automatic int f2(int c);
        return (e[c] + e[c+1] + 1) >> 1;
    endfunction

    function automatic int f3(int c);
        return (e[c-1] + 2*e[c] + e[c+1] + 2) >> 2;
    endfunction

    function automatic int model_pred(int m, int x, int y);
        int z;
        case (m)
            0: return e[5+x];
            1: return e[3-y];
            2: return (x == 3 && y == 3) ? (e[11] + 3*e[12] + 2) >> 2 : f3(6+x+y);
            3: return f3(4+x-y);
            4: begin
                z = 2*x - y;
                if (z == -1) return f3(4);
                if (z < -1) return f3(5-y);
                return (z % 2 == 0) ? f2(4+x-(y/2)) : f3(4+x-(y/2));
            end
            5: begin
                z = 2*y - x;
                if (z == -1) return f3(4);
                if (z < -1) return f3(3+x);
                return (z % 2 == 0) ? f2(3-y+(x/2)) : f3(4-y+(x/2));
            end
            6: return (y % 2 == 0) ? f2(5+x+(y/2)) : f3(6+x+(y/2));
            default: begin
                z = x + 2*y;
                if (z > 5) return e[0];
                if (z == 5) return (e[1] + 3*e[0] + 2) >> 2;
                return (z % 2 == 0) ? f2(2-y-(x/2)) : f3(2-y-(x/2));
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_nb(input int m, input logic [63:0] t, input logic [39:0] l);
        mode = 3'(m);
        top  = t;
        left = l;
        for (int k = 0; k < 8; k++) e[5+k] = int'(t[k*8 +: 8]);
        for (int k = 0; k < 5; k++) e[4-k] = int'(l[k*8 +: 8]);
    endtask

    task automatic model_block(input int m);
        int s;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                s = model_pred(m, x, y) + res_v[y][x];
                exp_pix[y][x] = (s < 0) ? 0 : (s > 255) ? 255 : s;
            end
        end
    endtask

    task automatic rand_res();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                res_v[y][x] = int'($urandom_range(0, 510)) - 255;
    endtask

    task automatic fill_res(input int v);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                res_v[y][x] = v;
    endtask

    task automatic send_cmd();
        int n;
        n = 0;
        cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_cmd: busy=%b want 1", busy);
        end
    endtask

    task automatic stream_block(input int stall_pct, input int stall_row, input int stall_len,
                                input int abort_after, input bit hold_cmd, output int span);
        int in_n, out_n, n, first_in, last_out, stalled;
        bit hs_in, hs_out;
        logic [4*PIX_W-1:0] er;
        in_n = 0; out_n = 0; n = 0; first_in = -1; last_out = -1; stalled = 0;
        while (out_n < abort_after && n < 200) begin
            if (rec_valid && out_n == stall_row && stalled < stall_len) begin
                rec_ready = 1'b0;
                stalled++;
            end else begin
                rec_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            res_valid = (in_n < 4);
            if (in_n < 4)
                for (int c = 0; c < 4; c++) res_row[c*RES_W +: RES_W] = RES_W'(res_v[in_n][c]);
            #1;
            if (rec_valid) begin
                er = '0;
                if (out_n < 4)
                    for (int c = 0; c < 4; c++) er[c*PIX_W +: PIX_W] = PIX_W'(exp_pix[out_n][c]);
                checks++;
                if (out_n > 3 || rec_row !== er || rec_idx !== 2'(out_n) || rec_last !== (out_n == 3)) begin
                    errors++;
                    $display("FAIL rec_row[%0d]: row=%h idx=%0d last=%b want row=%h idx=%0d last=%b",
                             out_n, rec_row, rec_idx, rec_last, er, out_n, (out_n == 3));
                end
            end
            if (rec_valid && !rec_ready) begin
                checks++;
                if (res_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL res_ready_backpressure: res_ready=%b want 0", res_ready);
                end
            end
            if (hold_cmd) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL cmd_ready_busy: cmd_ready=%b want 0", cmd_ready);
                end
            end
            hs_in  = res_valid && res_ready;
            hs_out = rec_valid && rec_ready;
            if (hs_in && first_in < 0) first_in = cyc;
            if (hs_out && out_n == 3) last_out = cyc;
            tick();
            n++;
            if (hs_in) in_n++;
            if (hs_out) out_n++;
        end
        res_valid = 1'b0;
        rec_ready = 1'b1;
        checks++;
        if (out_n < abort_after) begin
            errors++;
            $display("FAIL stream_timeout: rows_out=%0d want %0d", out_n, abort_after);
        end
        span = last_out - first_in;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: cmd_ready=%b busy=%b rec_valid=%b want 1 0 0", name, cmd_ready, busy, rec_valid);
        end
    endtask

    task automatic check_span(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: span=%0d cycles want %0d", name, got, want);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (cmd_ready !== 1'b0 || res_ready !== 1'b0 || rec_valid !== 1'b0 || rec_row !== '0 ||
            rec_idx !== 2'd0 || rec_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: cmd_ready=%b res_ready=%b rec_valid=%b rec_row=%h rec_idx=%0d rec_last=%b busy=%b want all 0",
                     name, cmd_ready, res_ready, rec_valid, rec_row, rec_idx, rec_last, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b0; res_valid = 1'b0; rec_ready = 1'b1;
        mode = '0; top = '0; left = '0; res_row = '0;
        tick();
        tick();
        check_reset_values("reset_state");
        reset = 1'b1;
        #1;
        check_idle("reset_release");
    endtask

    task automatic test_v_mode();
        logic [63:0] t;
        int span;
        t = {$urandom, $urandom};
        t[31:0] = {8'd40, 8'd30, 8'd20, 8'd10};
        load_nb(0, t, {8'($urandom), $urandom});
        fill_res(5);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) exp_pix[y][x] = 10*(x+1) + 5;
        send_cmd();
        stream_block(0, -1, 0, 4, 1'b0, span);
        check_span("v_latency", span, 4);
        check_idle("v_idle");
    endtask

    task automatic test_h_clip();
        int span;
        load_nb(1, {$urandom, $urandom}, {8'd250, 8'd200, 8'd150, 8'd100, 8'($urandom)});
        fill_res(10);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) exp_pix[y][x] = (y == 3) ? 255 : 110 + 50*y;
        send_cmd();
        stream_block(0, -1, 0, 4, 1'b0, span);
        check_idle("h_idle");
    endtask

    task automatic test_ddl_clip();
        int span;
        load_nb(2, {8{8'd128}}, {8'($urandom), $urandom});
        fill_res(-200);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) exp_pix[y][x] = 0;
        send_cmd();
        stream_block(0, -1, 0, 4, 1'b0, span);
        fill_res(-100);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) exp_pix[y][x] = 28;
        send_cmd();
        stream_block(0, -1, 0, 4, 1'b0, span);
        check_idle("ddl_idle");
    endtask

    task automatic test_backpressure();
        int span;
        load_nb(0, {$urandom, $urandom}, {8'($urandom), $urandom});
        rand_res();
        model_block(0);
        send_cmd();
        stream_block(0, 1, 3, 4, 1'b0, span);
        check_span("backpressure_span", span, 7);
        check_idle("backpressure_idle");
    endtask

    task automatic test_cmd_while_busy();
        int span, m2;
        load_nb(int'($urandom_range(0, 7)), {$urandom, $urandom}, {8'($urandom), $urandom});
        rand_res();
        model_block(int'(mode));
        send_cmd();
        m2 = int'($urandom_range(0, 7));
        load_nb(m2, {$urandom, $urandom}, {8'($urandom), $urandom});
        cmd_valid = 1'b1;
        stream_block(0, -1, 0, 4, 1'b1, span);
        check_idle("second_cmd_idle_slot");
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL second_cmd_accept: busy=%b want 1", busy);
        end
        rand_res();
        model_block(m2);
        stream_block(0, -1, 0, 4, 1'b0, span);
        check_span("second_block_span", span, 4);
        check_idle("second_block_idle");
    endtask

    task automatic test_reset_mid();
        int span;
        load_nb(int'($urandom_range(0, 7)), {$urandom, $urandom}, {8'($urandom), $urandom});
        rand_res();
        model_block(int'(mode));
        send_cmd();
        stream_block(0, -1, 0, 2, 1'b0, span);
        reset = 1'b0;
        tick();
        check_reset_values("reset_mid_values");
        reset = 1'b1;
        #1;
        check_idle("reset_mid_release");
        load_nb(0, {$urandom, $urandom}, {8'($urandom), $urandom});
        rand_res();
        model_block(0);
        send_cmd();
        stream_block(0, -1, 0, 4, 1'b0, span);
        check_span("post_reset_span", span, 4);
        check_idle("post_reset_idle");
    endtask

    task automatic test_random_blocks();
        int span, m;
        for (int b = 0; b < 40; b++) begin
            m = (b < 8) ? b : int'($urandom_range(0, 7));
            load_nb(m, {$urandom, $urandom}, {8'($urandom), $urandom});
            rand_res();
            model_block(m);
            send_cmd();
            stream_block((b < 8) ? 0 : 25, -1, 0, 4, 1'b0, span);
            check_idle("random_idle");
        end
    endtask

    initial begin
        test_reset();
        test_v_mode();
        test_h_clip();
        test_ddl_clip();
        test_backpressure();
        test_cmd_while_busy();
        test_reset_mid();
        test_random_blocks();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intrarecon_luma4x4.md
Name: intrarecon_luma4x4

Overview:
Decoder-side counterpart of the luma 4x4 intra encoder path. It takes a decided 3-bit mode, the 13 neighbouring pixels A..M and a 4x4 residual streamed one row per cycle, and outputs reconstructed rows `clip(pred + res)`. It feeds the reconstruction frame store and the neighbour source for the next 4x4 block.

Parameters:
- `RES_W`, 9: signed residual sample width (range -255..+255).
- `PIX_W`, 8: pixel width.

Ports:
- `clk`  in  1  — single clock.
- `reset`  in  1  — synchronous, active-low reset.
- `cmd_valid`  in  1  — mode/neighbour command valid.
- `cmd_ready`  out  1  — block accepts a command (IDLE only).
- `mode`  in  3  — intra mode; encoding below.
- `top`  in  8*PIX_W  — A..H, with A in bits [7:0].
- `left`  in  5*PIX_W  — M,I,J,K,L, with M in bits [7:0].
- `res_valid`  in  1  — residual row valid.
- `res_ready`  out  1  — residual row accepted this cycle when high with `res_valid`.
- `res_row`  in  4*RES_W  — 4 signed residuals; column 0 in the LSBs.
- `rec_valid`  out  1  — reconstructed row valid.
- `rec_ready`  in  1  — downstream accepts the row.
- `rec_row`  out  4*PIX_W  — reconstructed pixels, column 0 in the LSBs.
- `rec_idx`  out  2  — row index 0..3.
- `rec_last`  out  1  — high with row 3.
- `busy`  out  1  — high when state is not IDLE.

Behaviour:
- **Mode encoding:** 0 V, 1 H, 2 DDL, 3 DDR, 4 VR, 5 HD, 6 VL, 7 HU. Prediction equations follow H.264 §8.3.1.2 (Intra_4x4, DC excluded), with rounding `(a+2b+c+2)>>2` and `(a+b+1)>>1`.
- **FSM states:** IDLE, PRED, STREAM, DRAIN.
- **IDLE:**
  - `cmd_ready` = 1 while `reset` is high.
  - On `cmd_valid && cmd_ready`: register mode, top and left; go to PRED.
- **PRED:** one cycle. The combinational generator output is latched into a 16-entry prediction register, row counter is cleared to 0, then go to STREAM.
- **STREAM:**
  - `res_ready = !rec_valid || rec_ready`.
  - On a residual handshake, the next cycle presents `rec_valid=1` with `rec_row[c] = clip0_255(pred[row][c] + res[c])` and `rec_idx = row`; the row counter then increments.
  - Latency is one cycle from residual accept to `rec_valid`.
  - After row 3 is accepted: `res_ready` is 0 and the FSM goes to DRAIN.
- **DRAIN:** hold until the row-3 output handshake (`rec_valid && rec_ready`), then go to IDLE.
- **Output holding:** `rec_valid` stays high and `rec_row`, `rec_idx` and `rec_last` stay stable until `rec_ready`. Full throughput is 1 row/cycle when `rec_ready` is held at 1.
- **Arithmetic:**
  - Sum is computed in `RES_W+1` signed bits.
  - Negative results saturate to 0; results above 255 saturate to 255.
  - Neighbour sums are computed in 10 bits.
- **Command handling:** `cmd_valid` outside IDLE is ignored (`cmd_ready`=0). Commands are not queued.
- **Residual handling:** `res_valid` in IDLE, PRED or DRAIN is not accepted.
- **Reset:**
  - Synchronous, active-low, effective from any state, including mid-stream.
  - Values while `reset`=0: state IDLE, `cmd_ready`=0, `res_ready`=0, `rec_valid`=0, `rec_row`=0, `rec_idx`=0, `rec_last`=0, `busy`=0, prediction register cleared.
  - A partially streamed block is discarded.
  - `cmd_ready` returns to 1 in the first cycle with `reset`=1.
- **Mode 3'b111 (HU):** valid. No illegal modes exist.

Decomposition:
- Shared package `intrapred_pkg`:
  - Mode enum `luma4x4_mode_t` with the encoding above; the encoder's saver adopts the same enum.
  - `PIX_W` and `RES_W` constants.
  - `clip_pix` function.
- Sub-module `predgen_luma4x4`: purely combinational; inputs mode, A..M; output 16 predicted pixels. It is reusable by the encoder's moder.
- The top holds the FSM, the handshakes and the add/clip stage.

Test Plan:
1. **V mode:** mode=0, A..D = 10,20,30,40, all residuals +5 → each of 4 rows reads 15,25,35,45; `rec_idx` 0..3; `rec_last` only on row 3; 5 cycles from first `res_valid` to last output with `rec_ready`=1.
2. **H mode with upper clip:** mode=1, I,J,K,L = 100,150,200,250, residuals +10 → rows are 110×4, 160×4, 210×4, 255×4 (260 saturated).
3. **DDL with lower clip:** mode=2, A..H all 128, residuals -200 → all pixels 0. Same neighbours with residual -100 → all pixels 28.
4. **Backpressure:** `rec_ready`=0 for 3 cycles while row 1 is presented → `rec_valid`=1, `rec_row` and `rec_idx`=1 stable, `res_ready`=0; after release, rows 2 and 3 follow at 1 row/cycle.
5. **Command while busy:** a second `cmd_valid` during STREAM → `cmd_ready`=0 and the first block's outputs are unaffected. The second command is accepted in the IDLE cycle after the row-3 handshake.
6. **Reset mid-operation:** `reset`=0 for 1 cycle after row 1 output → next cycle all outputs 0 and `busy`=0; then `cmd_ready`=1 and a fresh V-mode block reconstructs correctly.
